// File: rtl/pc_return_stack.sv
// Return-address stack feeding the PC mux: CALL pushes PC_COUNT+1, RET pops.
// Ports: CLK, RST (sync, low), PUSH/POP/FLUSH, PC_COUNT in; FROM_STACK, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW out.
module pc_return_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic                     POP,
  input  logic                     FLUSH,
  input  logic [AW-1:0]            PC_COUNT,
  output logic [AW-1:0]            FROM_STACK,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] top_c;
  logic [PW-1:0] top;
  logic [PW-1:0] wr;
  logic [AW-1:0] ret;

  assign top_c = cnt - CW'(1);
  assign top   = top_c[PW-1:0];
  // Only used when not full, so cnt < DEPTH and the low bits are exact.
  assign wr    = cnt[PW-1:0];
  assign ret   = PC_COUNT + AW'(1);

  assign EMPTY      = (cnt == '0);
  assign FULL       = (cnt == CW'(DEPTH));
  assign COUNT      = cnt;
  assign FROM_STACK = EMPTY ? '0 : mem[top];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt       <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (FLUSH) begin
      cnt       <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      unique case (1'b1)
        // Replace the top: a RET immediately followed by a CALL.
        (PUSH && POP): begin
          if (EMPTY) begin
            mem[wr] <= ret;
            cnt     <= cnt + CW'(1);
          end else begin
            mem[top] <= ret;
          end
        end
        (PUSH && !POP): begin
          if (FULL) begin
            OVERFLOW <= 1'b1;
          end else begin
            mem[wr] <= ret;
            cnt     <= cnt + CW'(1);
          end
        end
        (POP && !PUSH): begin
          if (EMPTY) begin
            UNDERFLOW <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack.
// Drives one operation per cycle and checks outputs #1 after each edge.
module tb_pc_return_stack;

  logic       clk = 1'b0;
  logic       rst, push, pop, flush;
  logic [9:0] pc;
  logic [9:0] from_stack;
  logic       empty, full, ovf, unf;
  logic [3:0] count;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_return_stack #(.DEPTH(8), .AW(10)) dut (
    .CLK(clk), .RST(rst), .PUSH(push), .POP(pop), .FLUSH(flush),
    .PC_COUNT(pc), .FROM_STACK(from_stack), .EMPTY(empty),
    .FULL(full), .COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(unf)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic pu, input logic po,
                     input logic fl, input logic [9:0] p);
    rst = r; push = pu; pop = po; flush = fl; pc = p;
    @(posedge clk);
    #1;
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic do_push(input logic [9:0] p);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, p);
  endtask

  task automatic do_pop();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'h000);
  endtask

  task automatic do_flush();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; pc = '0;

    // Reset held with a push pending
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h050);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h050);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_top", from_stack, 10'h000);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);

    // Nested calls
    do_push(10'h010); check("call1", from_stack, 10'h011);
    do_push(10'h020); check("call2", from_stack, 10'h021);
    do_push(10'h030); check("call3", from_stack, 10'h031);
    check("call_cnt", count, 3);

    // Returns
    do_pop(); check("ret1", from_stack, 10'h021);
    do_pop(); check("ret2", from_stack, 10'h011);
    do_pop(); check("ret3", from_stack, 10'h000);
    check("ret_empty", empty, 1);

    // Wrap and fill
    do_push(10'h3FF); check("wrap", from_stack, 10'h000);
    check("wrap_cnt", count, 1);
    for (int i = 0; i < 7; i++) do_push(10'h200 + 10'(i));
    check("fill_full", full, 1);
    check("fill_top", from_stack, 10'h207);
    do_push(10'h100);
    check("ovf_set", ovf, 1);
    check("ovf_cnt", count, 8);
    check("ovf_top", from_stack, 10'h207);

    // Full + push/pop replaces top
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'h0A0);
    check("full_repl", from_stack, 10'h0A1);
    check("full_repl_cnt", count, 8);

    // Underflow
    do_flush();
    check("flush_ovf", ovf, 0);
    check("flush_cnt", count, 0);
    do_pop();
    check("unf_set", unf, 1);
    check("unf_cnt", count, 0);
    do_push(10'h0B4);
    check("unf_push", from_stack, 10'h0B5);
    check("unf_sticky", unf, 1);

    // Simultaneous push and pop
    do_flush();
    do_push(10'h010);
    do_push(10'h020);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'h003);
    check("repl_top", from_stack, 10'h004);
    check("repl_cnt", count, 2);
    do_pop(); check("repl_lower", from_stack, 10'h011);
    do_pop();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'h003);
    check("pp_empty_cnt", count, 1);
    check("pp_empty_top", from_stack, 10'h004);
    check("pp_empty_unf", unf, 0);

    // Flush beats push
    do_flush();
    for (int i = 0; i < 8; i++) do_push(10'h040 + 10'(i));
    do_push(10'h100);
    do_pop(); do_pop(); do_pop();
    check("pre_fl_cnt", count, 5);
    check("pre_fl_ovf", ovf, 1);
    check("pre_fl_top", from_stack, 10'h045);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 10'h123);
    check("fl_cnt", count, 0);
    check("fl_ovf", ovf, 0);
    check("fl_unf", unf, 0);

    // Reset beats flush and pop
    do_pop();
    do_push(10'h060);
    do_push(10'h070);
    check("pre_rst_unf", unf, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
    check("rst2_cnt", count, 0);
    check("rst2_empty", empty, 1);
    check("rst2_top", from_stack, 10'h000);
    check("rst2_unf", unf, 0);
    check("rst2_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Hardware return-address stack directly upstream of the program counter: it produces the `FROM_STACK` value that the PC loads when its mux select is 1. On a CALL the control unit pulses `PUSH` and the block stores `PC_COUNT + 1`; on a RET it pulses `POP`, and the PC captures `FROM_STACK` on the same clock edge that removes the entry. The block tracks depth and reports full/empty status plus sticky overflow/underflow errors.

## Interface
- `DEPTH`, 8: number of stack entries; a power of two, from 2 to 64.
- `AW`, 10: address width; matches the PC width.
- `CLK` in 1: system clock. All state changes on its rising edge.
- `RST` in 1: synchronous, active-low reset. `RST=0` at a rising edge resets the block.
- `PUSH` in 1: push `PC_COUNT + 1` this cycle.
- `POP` in 1: remove the top entry this cycle.
- `FLUSH` in 1: empty the stack and clear the error flags (synchronous).
- `PC_COUNT` in AW: current PC value, taken from the program counter output.
- `FROM_STACK` out AW: the top entry, or 0 when the stack is empty. Feeds the PC mux input 1.
- `EMPTY` out 1: count == 0.
- `FULL` out 1: count == DEPTH.
- `COUNT` out clog2(DEPTH)+1: number of valid entries.
- `OVERFLOW` out 1: sticky; set by a push while full.
- `UNDERFLOW` out 1: sticky; set by a pop while empty.

## Operation
- Storage is DEPTH×AW registers plus a count register. `top = count-1`.
- Return address = `PC_COUNT + 1`, truncated to AW bits. `3FF` wraps to `000`.
- Priority per edge: `RST=0`, then `FLUSH`, then `PUSH`/`POP`.
- Reset: count=0, all entries=0, `OVERFLOW=UNDERFLOW=0`.
  - Outputs after the reset edge: `FROM_STACK=0`, `EMPTY=1`, `FULL=0`, `COUNT=0`.
- `FLUSH`: count=0, both error flags cleared. Entry contents need not be cleared.
- `PUSH` only:
  - Not full: write entry[count] and increment count.
  - Full: no write, count unchanged, `OVERFLOW←1`.
- `POP` only:
  - Not empty: decrement count. The popped entry is not cleared.
  - Empty: no change, `UNDERFLOW←1`.
- `PUSH` and `POP` together:
  - Not empty: overwrite entry[top] with the new return address; count unchanged; no flags. This also applies when full.
  - Empty: behaves as a push only; no underflow.
- `RST=0` mid-operation aborts any push or pop in that cycle. Reset state results regardless of other inputs.
- The error flags stay set until `FLUSH` or reset. They do not block further pushes or pops.

## Timing
- `FROM_STACK`, `EMPTY`, `FULL` and `COUNT` are combinational from registered state only. There is no input-to-output combinational path.
- Push latency: the address pushed at edge k appears on `FROM_STACK` after edge k.
- RET handshake:
  - The control unit asserts `POP` together with the PC load (mux select 1) in the same cycle.
  - At that edge the PC captures the pre-pop `FROM_STACK`.
  - After the edge, `FROM_STACK` shows the next-lower entry, or 0 if the stack is now empty.
- CALL handshake: `PUSH` is asserted in the cycle where `PC_COUNT` holds the CALL instruction's address, so the stored value is CALL address + 1.
- Throughput: one push, pop or replace per cycle, sustained, with no stalls.

## Test plan
- Reset behaviour: hold `RST=0` for 2 cycles with `PUSH=1` and `PC_COUNT=0x050` → `COUNT=0`, `EMPTY=1`, `FROM_STACK=0x000`, both flags 0.
- Nested calls and returns:
  - Push with `PC_COUNT`=0x010, 0x020, 0x030 → `FROM_STACK` reads 0x011, 0x021, 0x031 in turn; `COUNT=3`.
  - Three pops → `FROM_STACK` reads 0x021, 0x011, 0x000; `EMPTY=1`.
- Wrap and fill:
  - Push with `PC_COUNT=0x3FF` → `FROM_STACK=0x000`.
  - Push 7 more (DEPTH=8) → `FULL=1`.
  - A 9th push with `PC_COUNT=0x100` → `OVERFLOW=1`, `COUNT=8`, top unchanged.
- Underflow: pop on an empty stack → `UNDERFLOW=1`, `COUNT=0`. A following push with `PC_COUNT=0x0B4` → `FROM_STACK=0x0B5` and `UNDERFLOW` stays 1.
- Simultaneous push and pop:
  - With `COUNT=2`, top=0x021 and `PC_COUNT=0x003` → top=0x004, `COUNT=2`.
  - When empty, the same input → `COUNT=1`, `FROM_STACK=0x004`, no `UNDERFLOW`.
- Flush versus reset:
  - With `COUNT=5` and `OVERFLOW=1`, `FLUSH` together with `PUSH` → `COUNT=0`, flags 0.
  - `RST=0` together with `FLUSH` and `POP` → reset state.
